accessory_port: RTL and testbench

Accessory-side endpoint of the G-15 PL19/PL20 accessory connectors: it is the responder that the CPU's PL19 input commands and PL20 output shifts talk to. On PL19 it serialises host-supplied words onto PL19_INPUT, one bit per CPU shift command, LSB first. On PL20 it deserialises PL20_OUTPUT bits into words for the host. It sits between the FPGA host bridge (parallel valid/ready) and the CPU top-level accessory pins, all in the CLOCK domain.

---
 rtl/accessory_port.sv | 141 ++++++++++++++
 tb/tb_accessory_port.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accessory_port.sv
// G-15 PL19/PL20 accessory responder: host words out to the CPU bit-serially, CPU output bits assembled into host words.
// CPU strobes act two cycles after they are sampled; tx is valid/ready with one holding slot, rx is valid/ack with sticky overrun.
module accessory_port #(
  parameter int WORD_BITS = 29
) (
  input  logic                 CLOCK,
  input  logic                 rst_n,
  input  logic                 PL19_START_INPUT,
  input  logic                 PL19_STOP_INPUT,
  input  logic                 PL19_SHIFT_CMD,
  output logic                 PL19_INPUT,
  output logic                 PL19_READY_IN,
  input  logic                 PL20_OUTPUT,
  input  logic                 PL20_OUTPUT_SHIFT,
  output logic                 PL20_READY_OUT,
  input  logic [WORD_BITS-1:0] tx_word,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_overrun
);

  localparam int CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

  // Sample and previous registers reset high so a strobe held across reset release is not an edge.
  logic [3:0] smp;
  logic [3:0] prv;
  logic       out_dat;
  logic       start_e, stop_e, shift_e, oshift_e;

  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      smp     <= '1;
      prv     <= '1;
      out_dat <= 1'b0;
    end else begin
      smp     <= {PL20_OUTPUT_SHIFT, PL19_SHIFT_CMD, PL19_STOP_INPUT, PL19_START_INPUT};
      prv     <= smp;
      out_dat <= PL20_OUTPUT;
    end
  end

  assign {oshift_e, shift_e, stop_e, start_e} = smp & ~prv;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} in_state_t;

  in_state_t            state;
  logic [WORD_BITS-1:0] hold;
  logic                 hold_full;
  logic [WORD_BITS-1:0] shreg;
  logic [CW-1:0]        bit_cnt;

  assign tx_ready   = !hold_full;
  // shreg is zero outside SEND (cleared on stop, fully shifted out on the last bit), so bit 0 is the line.
  assign PL19_INPUT = shreg[0];

  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      hold_full     <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      PL19_READY_IN <= 1'b0;
    end else begin
      if (tx_valid && !hold_full) begin
        hold      <= tx_word;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_e) state <= LOAD;
        end
        LOAD: begin
          if (stop_e) begin
            state <= IDLE;
          end else if (hold_full) begin
            shreg         <= hold;
            bit_cnt       <= '0;
            hold_full     <= 1'b0;
            PL19_READY_IN <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (stop_e) begin
            shreg         <= '0;
            PL19_READY_IN <= 1'b0;
            state         <= IDLE;
          end else if (shift_e) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST) begin
              PL19_READY_IN <= 1'b0;
              state         <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rx_shreg holds the bits gathered so far; the newest bit enters at the top.
  logic [WORD_BITS-2:0] rx_shreg;
  logic [WORD_BITS-1:0] rx_next;
  logic [CW-1:0]        rx_cnt;

  assign rx_next        = {out_dat, rx_shreg};
  assign PL20_READY_OUT = !rx_valid;

  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      rx_shreg   <= '0;
      rx_cnt     <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (oshift_e) begin
        if (rx_valid) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_shreg <= rx_next[WORD_BITS-1:1];
          if (rx_cnt == LAST) begin
            rx_word  <= rx_next;
            rx_valid <= 1'b1;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      end
      if (rx_ack && rx_valid) rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_accessory_port.sv
// Bench for accessory_port: hand-written vector table, cycle-exact corner sequences, and random ops against a word-level model.
module tb_accessory_port;

  localparam int W = 29;

  logic         CLOCK = 1'b0;
  logic         rst_n = 1'b0;
  logic         PL19_START_INPUT = 1'b0;
  logic         PL19_STOP_INPUT = 1'b0;
  logic         PL19_SHIFT_CMD = 1'b0;
  logic         PL19_INPUT;
  logic         PL19_READY_IN;
  logic         PL20_OUTPUT = 1'b0;
  logic         PL20_OUTPUT_SHIFT = 1'b0;
  logic         PL20_READY_OUT;
  logic [W-1:0] tx_word = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic         rx_ack = 1'b0;
  logic         rx_overrun;

  accessory_port #(.WORD_BITS(W)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n),
    .PL19_START_INPUT(PL19_START_INPUT), .PL19_STOP_INPUT(PL19_STOP_INPUT),
    .PL19_SHIFT_CMD(PL19_SHIFT_CMD), .PL19_INPUT(PL19_INPUT), .PL19_READY_IN(PL19_READY_IN),
    .PL20_OUTPUT(PL20_OUTPUT), .PL20_OUTPUT_SHIFT(PL20_OUTPUT_SHIFT), .PL20_READY_OUT(PL20_READY_OUT),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_ack(rx_ack), .rx_overrun(rx_overrun)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_fail = 0;

  // Word-level model: which word is being offered and which bit of it, plus the host-side slots.
  bit           m_active, m_cur_valid, m_hold_full, m_rxv, m_ovr;
  int           m_idx, m_rcnt;
  logic [W-1:0] m_cur, m_hold, m_rx_word, m_acc;

  typedef enum int {OP_NOP, OP_PUSH, OP_START, OP_STOP, OP_SHIFT, OP_RXBIT, OP_ACK, OP_STOPSHIFT} op_t;

  typedef struct {
    op_t          op;
    logic [W-1:0] arg;
    logic         e_rdy_in, e_in, e_tx_rdy, e_rxv, e_rdy_out, e_ovr;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_active = 0; m_cur_valid = 0; m_hold_full = 0; m_rxv = 0; m_ovr = 0;
    m_idx = 0; m_rcnt = 0; m_cur = '0; m_hold = '0; m_rx_word = '0; m_acc = '0;
  endfunction

  function automatic void m_settle();
    if (m_active && !m_cur_valid && m_hold_full) begin
      m_cur = m_hold; m_idx = 0; m_cur_valid = 1; m_hold_full = 0;
    end
  endfunction

  function automatic void m_push(input logic [W-1:0] w);
    if (!m_hold_full) begin m_hold = w; m_hold_full = 1; end
  endfunction

  function automatic void m_start();
    if (!m_active) begin m_active = 1; m_cur_valid = 0; end
  endfunction

  function automatic void m_stop();
    m_active = 0; m_cur_valid = 0;
  endfunction

  function automatic void m_shift();
    if (m_active && m_cur_valid) begin
      m_idx++;
      if (m_idx == W) m_cur_valid = 0;
    end
  endfunction

  function automatic void m_rxbit(input logic b);
    if (m_rxv) m_ovr = 1;
    else begin
      m_acc[m_rcnt] = b;
      m_rcnt++;
      if (m_rcnt == W) begin m_rx_word = m_acc; m_rxv = 1; m_rcnt = 0; end
    end
  endfunction

  task automatic check_model(input string nm);
    logic er, ei;
    er = m_active && m_cur_valid;
    ei = er ? m_cur[m_idx] : 1'b0;
    chk({nm, ":ready_in"}, PL19_READY_IN, er);
    chk({nm, ":input"}, PL19_INPUT, ei);
    chk({nm, ":tx_ready"}, tx_ready, !m_hold_full);
    chk({nm, ":rx_valid"}, rx_valid, m_rxv);
    chk({nm, ":ready_out"}, PL20_READY_OUT, !m_rxv);
    chk({nm, ":overrun"}, rx_overrun, m_ovr);
    chk({nm, ":rx_word"}, rx_word, m_rx_word);
  endtask

  // One strobe pulse, one cycle high, then three low so every action has settled before the next.
  task automatic pulse(input logic st, input logic sp, input logic sh, input logic os, input logic b);
    PL19_START_INPUT = st; PL19_STOP_INPUT = sp; PL19_SHIFT_CMD = sh;
    PL20_OUTPUT_SHIFT = os; PL20_OUTPUT = b;
    tick();
    PL19_START_INPUT = 0; PL19_STOP_INPUT = 0; PL19_SHIFT_CMD = 0; PL20_OUTPUT_SHIFT = 0;
    tick(); tick(); tick();
  endtask

  task automatic apply_op(input op_t op, input logic [W-1:0] arg);
    case (op)
      OP_PUSH: begin
        tx_word = arg; tx_valid = 1; tick(); tx_valid = 0; tick(); tick(); tick();
        m_push(arg);
      end
      OP_START:     begin pulse(1, 0, 0, 0, 0); m_start(); end
      OP_STOP:      begin pulse(0, 1, 0, 0, 0); m_stop(); end
      OP_SHIFT:     begin pulse(0, 0, 1, 0, 0); m_shift(); end
      OP_RXBIT:     begin pulse(0, 0, 0, 1, arg[0]); m_rxbit(arg[0]); end
      OP_STOPSHIFT: begin pulse(0, 1, 1, 0, 0); m_stop(); end
      OP_ACK: begin
        rx_ack = 1; tick(); rx_ack = 0; tick(); tick(); tick();
        m_rxv = 0;
      end
      default: begin tick(); tick(); tick(); tick(); end
    endcase
    m_settle();
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
    m_reset();
  endtask

  task automatic start_precise(input string nm);
    PL19_START_INPUT = 1; tick(); PL19_START_INPUT = 0;
    chk({nm, ":n1_rdy"}, PL19_READY_IN, 0);
    tick(); chk({nm, ":n2_rdy"}, PL19_READY_IN, 0);
    tick(); chk({nm, ":n3_rdy"}, PL19_READY_IN, 1);
    chk({nm, ":n3_bit0"}, PL19_INPUT, m_hold[0]);
    tick();
    m_start(); m_settle(); check_model(nm);
  endtask

  task automatic last_shift(input logic reload, input string nm);
    PL19_SHIFT_CMD = 1; tick(); PL19_SHIFT_CMD = 0;
    chk({nm, ":m1_rdy"}, PL19_READY_IN, 1);
    tick(); chk({nm, ":m2_rdy"}, PL19_READY_IN, 0);
    tick(); chk({nm, ":m3_rdy"}, PL19_READY_IN, reload);
    tick();
    m_shift(); m_settle(); check_model(nm);
  endtask

  task automatic rx_last(input logic b, input string nm);
    PL20_OUTPUT = b; PL20_OUTPUT_SHIFT = 1; tick(); PL20_OUTPUT_SHIFT = 0;
    chk({nm, ":k1_rxv"}, rx_valid, 0);
    tick(); chk({nm, ":k2_rxv"}, rx_valid, 1);
    chk({nm, ":k2_rdy_out"}, PL20_READY_OUT, 0);
    tick(); tick();
    m_rxbit(b); check_model(nm);
  endtask

  task automatic rx_word_in(input logic [W-1:0] v, input string nm);
    for (int i = 0; i < W; i++) apply_op(OP_RXBIT, {{(W-1){1'b0}}, v[i]});
    check_model(nm);
  endtask

  initial begin
    logic [W-1:0] w1, w2, w3, w4, v;
    int r;

    tbl[0]  = '{OP_NOP,      29'h0,        0, 0, 1, 0, 1, 0};
    tbl[1]  = '{OP_PUSH,     29'h5,        0, 0, 0, 0, 1, 0};
    tbl[2]  = '{OP_START,    29'h0,        1, 1, 1, 0, 1, 0};
    tbl[3]  = '{OP_SHIFT,    29'h0,        1, 0, 1, 0, 1, 0};
    tbl[4]  = '{OP_SHIFT,    29'h0,        1, 1, 1, 0, 1, 0};
    tbl[5]  = '{OP_STOP,     29'h0,        0, 0, 1, 0, 1, 0};
    tbl[6]  = '{OP_PUSH,     29'h2,        0, 0, 0, 0, 1, 0};
    tbl[7]  = '{OP_START,    29'h0,        1, 0, 1, 0, 1, 0};
    tbl[8]  = '{OP_SHIFT,    29'h0,        1, 1, 1, 0, 1, 0};
    tbl[9]  = '{OP_RXBIT,    29'h1,        1, 1, 1, 0, 1, 0};
    tbl[10] = '{OP_ACK,      29'h0,        1, 1, 1, 0, 1, 0};
    tbl[11] = '{OP_PUSH,     29'h1FFFFFFF, 1, 1, 0, 0, 1, 0};
    tbl[12] = '{OP_STOP,     29'h0,        0, 0, 0, 0, 1, 0};
    tbl[13] = '{OP_START,    29'h0,        1, 1, 1, 0, 1, 0};

    // Reset values, with START and SHIFT held high across release: neither may count as an edge.
    PL19_START_INPUT = 1; PL19_SHIFT_CMD = 1;
    rst_n = 0; tick(); tick();
    chk("rst:ready_in", PL19_READY_IN, 0);
    chk("rst:input", PL19_INPUT, 0);
    chk("rst:tx_ready", tx_ready, 1);
    chk("rst:rx_valid", rx_valid, 0);
    chk("rst:ready_out", PL20_READY_OUT, 1);
    chk("rst:overrun", rx_overrun, 0);
    chk("rst:rx_word", rx_word, 0);
    rst_n = 1; tick(); tick(); tick();
    m_reset();
    apply_op(OP_PUSH, 29'h0123457);
    chk("rel:no_start", PL19_READY_IN, 0);
    PL19_START_INPUT = 0; PL19_SHIFT_CMD = 0; tick(); tick(); tick();
    apply_op(OP_START, 29'h0);
    check_model("rel:start_bit0");

    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply_op(tbl[i].op, tbl[i].arg);
      chk($sformatf("vec%0d:ready_in", i), PL19_READY_IN, tbl[i].e_rdy_in);
      chk($sformatf("vec%0d:input", i), PL19_INPUT, tbl[i].e_in);
      chk($sformatf("vec%0d:tx_ready", i), tx_ready, tbl[i].e_tx_rdy);
      chk($sformatf("vec%0d:rx_valid", i), rx_valid, tbl[i].e_rxv);
      chk($sformatf("vec%0d:ready_out", i), PL20_READY_OUT, tbl[i].e_rdy_out);
      chk($sformatf("vec%0d:overrun", i), rx_overrun, tbl[i].e_ovr);
    end

    // Send 29'h0ABCDEF with a second word preloaded mid-way, then send the second to empty.
    do_reset();
    w1 = 29'h0ABCDEF; w2 = 29'h1234567;
    apply_op(OP_PUSH, w1);
    start_precise("tx1_start");
    for (int i = 0; i < W - 1; i++) begin
      if (i == 5) apply_op(OP_PUSH, w2);
      apply_op(OP_SHIFT, 29'h0);
      check_model($sformatf("tx1_bit%0d", i + 1));
    end
    last_shift(1'b1, "tx1_last_b2b");
    for (int i = 0; i < W - 1; i++) apply_op(OP_SHIFT, 29'h0);
    check_model("tx2_bit28");
    last_shift(1'b0, "tx2_last");
    tick(); tick();
    chk("tx2_idle_rdy", PL19_READY_IN, 0);
    chk("tx2_idle_txrdy", tx_ready, 1);

    // STOP mid-word keeps the held word; a coincident STOP+SHIFT must not leave the FSM sending.
    w3 = 29'h0F0F0F3; w4 = 29'h1AAAAAB;
    apply_op(OP_PUSH, w3);
    apply_op(OP_SHIFT, 29'h0);
    for (int i = 0; i < 10; i++) apply_op(OP_SHIFT, 29'h0);
    check_model("stop_pre");
    apply_op(OP_PUSH, w4);
    PL19_STOP_INPUT = 1; tick(); PL19_STOP_INPUT = 0;
    chk("stop:n1_rdy", PL19_READY_IN, 1);
    tick();
    chk("stop:n2_rdy", PL19_READY_IN, 0);
    chk("stop:n2_input", PL19_INPUT, 0);
    tick(); tick();
    m_stop(); check_model("stop:hold_kept");
    apply_op(OP_START, 29'h0);
    check_model("stop:restart_bit0");
    for (int i = 0; i < 3; i++) apply_op(OP_SHIFT, 29'h0);
    apply_op(OP_STOPSHIFT, 29'h0);
    check_model("stopshift");

    // Receive, cycle-exact valid rise and ack release.
    do_reset();
    v = 29'h15555555;
    for (int i = 0; i < W - 1; i++) apply_op(OP_RXBIT, {{(W-1){1'b0}}, v[i]});
    rx_last(v[W-1], "rx1");
    chk("rx1:word_const", rx_word, 29'h15555555);
    rx_ack = 1; tick(); rx_ack = 0;
    chk("rx1:ack_rxv", rx_valid, 0);
    chk("rx1:ack_rdy_out", PL20_READY_OUT, 1);
    tick(); tick();
    m_rxv = 0;

    // Overrun while full; then a fresh word assembles correctly.
    rx_word_in(29'h0C3A5F1, "rx2");
    apply_op(OP_RXBIT, 29'h1);
    check_model("ovr1");
    apply_op(OP_ACK, 29'h0);
    rx_word_in(29'h1E01234, "rx3");

    // An edge detected in the same cycle as the ack is judged against pre-ack readiness.
    do_reset();
    rx_word_in(29'h0777777, "rx4");
    PL20_OUTPUT = 1; PL20_OUTPUT_SHIFT = 1; tick(); PL20_OUTPUT_SHIFT = 0;
    rx_ack = 1; tick(); rx_ack = 0; tick(); tick();
    m_ovr = 1; m_rxv = 0;
    check_model("ack_edge_ovr");
    rx_word_in(29'h1234ABC, "rx5");

    // Reset in the middle of both paths clears everything, including hold and overrun.
    apply_op(OP_ACK, 29'h0);
    for (int i = 0; i < 10; i++) apply_op(OP_RXBIT, 29'h1);
    apply_op(OP_PUSH, 29'h0000F0F);
    apply_op(OP_START, 29'h0);
    apply_op(OP_SHIFT, 29'h0);
    apply_op(OP_PUSH, 29'h1111111);
    rst_n = 0; tick(); tick();
    chk("mrst:ready_in", PL19_READY_IN, 0);
    chk("mrst:input", PL19_INPUT, 0);
    chk("mrst:tx_ready", tx_ready, 1);
    chk("mrst:rx_valid", rx_valid, 0);
    chk("mrst:ready_out", PL20_READY_OUT, 1);
    chk("mrst:overrun", rx_overrun, 0);
    chk("mrst:rx_word", rx_word, 0);
    rst_n = 1; tick();
    m_reset();
    rx_word_in(29'h0DEAD5B, "mrst_rx");

    // Random operations against the word-level model.
    do_reset();
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 32)      apply_op(OP_SHIFT, 29'h0);
      else if (r < 58) apply_op(OP_RXBIT, W'($urandom));
      else if (r < 70) apply_op(OP_PUSH, W'($urandom));
      else if (r < 77) apply_op(OP_START, 29'h0);
      else if (r < 78) apply_op(OP_STOP, 29'h0);
      else if (r < 79) apply_op(OP_STOPSHIFT, 29'h0);
      else if (r < 88) apply_op(OP_ACK, 29'h0);
      else             apply_op(OP_NOP, 29'h0);
      check_model($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
